// File: rtl/fadd_result_queue.sv
// Result capture and flow control behind the 3-stage FP adder.
// Tracks in-flight tokens, drives the adder enable and queues finished sums.
module fadd_result_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          clrn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          e,
  input  logic [31:0]   s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [3:0]    out_flags,
  output logic [AW:0]   count
);

  logic          v_c_q, v_c_d;
  logic          v_n_q, v_n_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [35:0]   mem_q [DEPTH];
  logic          full;
  logic          pop;
  logic          push;
  logic [3:0]    flags_s;
  logic [35:0]   head;

  assign flags_s = {
    (&s[30:23]) & (|s[22:0]),
    (&s[30:23]) & ~(|s[22:0]),
    ~(|s[30:0]),
    ~(|s[30:23]) & (|s[22:0])
  };

  assign count     = wr_q - rd_q;
  assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0])
                   & (wr_q[AW] != rd_q[AW]);
  assign out_valid = (wr_q != rd_q);
  assign pop       = out_valid & out_ready & ~flush;
  // Stall only when a finished result has nowhere to go.
  assign e         = flush | ~(v_n_q & full & ~pop);
  assign in_ready  = e;
  assign push      = v_n_q & e & ~flush;

  assign head      = mem_q[rd_q[AW-1:0]];
  assign out_data  = out_valid ? head[31:0]  : 32'h0;
  assign out_flags = out_valid ? head[35:32] : 4'h0;

  always_comb begin
    v_c_d = v_c_q;
    v_n_d = v_n_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      v_c_d = 1'b0;
      v_n_d = 1'b0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      if (e) begin
        v_c_d = in_valid;
        v_n_d = v_c_q;
      end
      if (push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      v_c_q <= 1'b0;
      v_n_q <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      v_c_q <= v_c_d;
      v_n_q <= v_n_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= {flags_s, s};
    end
  end

endmodule

// File: tb/tb_fadd_result_queue.sv
// Directed bench for fadd_result_queue with a behavioural
// 3-stage adder model that carries hand-computed sums.
module tb_fadd_result_queue;

  logic        clock;
  logic        clrn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        e;
  logic [31:0] s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [2:0]  count;

  logic [31:0] sum_in;
  logic [31:0] c_q, n_q;

  int checks;
  int failures;

  fadd_result_queue #(.DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e         (e),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Adder pipeline: align -> reg -> cal -> reg -> norm (s).
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      c_q <= '0;
      n_q <= '0;
    end else if (e) begin
      c_q <= in_valid ? sum_in : 32'hDEADBEEF;
      n_q <= c_q;
    end
  end
  assign s = n_q;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    clrn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; sum_in = 32'hDEADBEEF;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL reset_e got %b exp 1", e); end
    tick; tick;
    @(negedge clock);
    clrn = 1'b1;
  endtask

  task automatic test_single;
    tick;
    in_valid = 1'b1; sum_in = 32'h40400000;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got %b exp 1", in_ready); end
    tick;
    in_valid = 1'b0; sum_in = 32'hDEADBEEF;
    tick; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got %b exp 0", out_valid); end
    tick; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h40400000) begin failures++; $display("FAIL single_data got %h exp 40400000", out_data); end
    checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL single_flags got %b exp 0000", out_flags); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got %0d exp 1", count); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_drain got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [6];
    int acc;
    int got;
    exp = '{32'h40000000, 32'h40800000, 32'h40C00000,
            32'h41000000, 32'h41200000, 32'h41400000};
    acc = 0; got = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick;
      in_valid = (acc < 6);
      sum_in = 32'hDEADBEEF;
      if (acc < 6) sum_in = exp[acc];
      #1;
      if (in_valid && in_ready) acc++;
    end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (acc !== 6) begin failures++; $display("FAIL b2b_accepted got %0d exp 6", acc); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL b2b_full got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall got %b exp 0", in_ready); end
    checks++; if (out_data !== exp[0]) begin failures++; $display("FAIL b2b_head got %h exp %h", out_data, exp[0]); end
    out_ready = 1'b1;
    #1;
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL b2b_e_pop got %b exp 1", e); end
    tick;
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL b2b_popush got %0d exp 4", count); end
    checks++; if (out_data !== exp[1]) begin failures++; $display("FAIL b2b_head2 got %h exp %h", out_data, exp[1]); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL b2b_restall got %b exp 0", e); end
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      tick;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== exp[got+1]) begin failures++; $display("FAIL b2b_order[%0d] got %h exp %h", got + 1, out_data, exp[got+1]); end
        got++;
      end
    end
    checks++; if (got !== 5) begin failures++; $display("FAIL b2b_drained got %0d exp 5", got); end
    tick;
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_empty got %0d exp 0", count); end
  endtask

  task automatic test_full_stream;
    logic [31:0] vals [14];
    int acc;
    int got;
    for (int i = 0; i < 14; i++) vals[i] = 32'h41000000 + 32'(i) * 32'h00010000;
    acc = 0; got = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick;
      in_valid = (acc < 14);
      sum_in = vals[acc];
      #1;
      if (in_valid && in_ready) acc++;
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick;
      in_valid = (acc < 14);
      sum_in = 32'hDEADBEEF;
      if (acc < 14) sum_in = vals[acc];
      out_ready = 1'b1;
      #1;
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL stream_count[%0d] got %0d exp 4", cyc, count); end
      if (out_valid) begin
        checks++; if (out_data !== vals[got]) begin failures++; $display("FAIL stream_order[%0d] got %h exp %h", got, out_data, vals[got]); end
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    checks++; if (acc !== 14) begin failures++; $display("FAIL stream_accepted got %0d exp 14", acc); end
    for (int cyc = 0; cyc < 30 && got < 14; cyc++) begin
      tick;
      in_valid = 1'b0;
      sum_in = 32'hDEADBEEF;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== vals[got]) begin failures++; $display("FAIL stream_order[%0d] got %h exp %h", got, out_data, vals[got]); end
        got++;
      end
    end
    checks++; if (got !== 14) begin failures++; $display("FAIL stream_drained got %0d exp 14", got); end
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_flags;
    logic [31:0] sums [4];
    logic [3:0]  flg [4];
    int acc;
    int got;
    sums = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000002};
    flg  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    acc = 0; got = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick;
      in_valid = (acc < 4);
      sum_in = 32'hDEADBEEF;
      if (acc < 4) sum_in = sums[acc];
      #1;
      if (in_valid && in_ready) acc++;
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL flags_count got %0d exp 4", count); end
    for (int cyc = 0; cyc < 10 && got < 4; cyc++) begin
      tick;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++; if (out_data !== sums[got]) begin failures++; $display("FAIL flags_data[%0d] got %h exp %h", got, out_data, sums[got]); end
        checks++; if (out_flags !== flg[got]) begin failures++; $display("FAIL flags_class[%0d] got %b exp %b", got, out_flags, flg[got]); end
        got++;
      end
    end
    checks++; if (got !== 4) begin failures++; $display("FAIL flags_drained got %0d exp 4", got); end
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      in_valid = 1'b1;
      sum_in = 32'h42000000 + 32'(i);
    end
    tick;
    in_valid = 1'b0;
    sum_in = 32'hDEADBEEF;
    flush = 1'b1;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre got %0d exp 3", count); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL flush_e got %b exp 1", e); end
    tick;
    flush = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale[%0d] got %b exp 0", cyc, out_valid); end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      in_valid = 1'b1;
      sum_in = 32'h43000000 + 32'(i);
    end
    tick;
    in_valid = 1'b0;
    sum_in = 32'hDEADBEEF;
    tick; tick;
    #1;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL arst_pre got %0d exp 2", count); end
    #2;
    clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL arst_count got %0d exp 0", count); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL arst_data got %h exp 0", out_data); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL arst_flags got %b exp 0", out_flags); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL arst_e got %b exp 1", e); end
    #2;
    clrn = 1'b1;
    tick;
    in_valid = 1'b1;
    sum_in = 32'h40A00000;
    tick;
    in_valid = 1'b0;
    sum_in = 32'hDEADBEEF;
    tick; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_early got %b exp 0", out_valid); end
    tick; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_lat got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h40A00000) begin failures++; $display("FAIL arst_data2 got %h exp 40A00000", out_data); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL arst_count2 got %0d exp 1", count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_full_stream;
    test_flags;
    test_flush;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
